// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: MIPS opcode/funct encodings, one-hot bit positions and the stage entry record
package mips_isa_pkg;
   localparam int DEC_W = 32;
   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                          OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
                          OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E,
                          OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
   localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_SLLV = 6'h04,
                          FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR = 6'h08, FN_ADD = 6'h20,
                          FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23, FN_AND = 6'h24,
                          FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2A,
                          FN_SLTU = 6'h2B;
   localparam int ONEHOT_ADD = 0, ONEHOT_ADDU = 1, ONEHOT_SUB = 2, ONEHOT_SUBU = 3,
                  ONEHOT_AND = 4, ONEHOT_OR = 5, ONEHOT_XOR = 6, ONEHOT_NOR = 7,
                  ONEHOT_SLT = 8, ONEHOT_SLTU = 9, ONEHOT_SLL = 10, ONEHOT_SRL = 11,
                  ONEHOT_SRA = 12, ONEHOT_SLLV = 13, ONEHOT_SRLV = 14, ONEHOT_SRAV = 15,
                  ONEHOT_JR = 16, ONEHOT_ADDI = 17, ONEHOT_ADDIU = 18, ONEHOT_ANDI = 19,
                  ONEHOT_ORI = 20, ONEHOT_XORI = 21, ONEHOT_LUI = 22, ONEHOT_LW = 23,
                  ONEHOT_SW = 24, ONEHOT_BEQ = 25, ONEHOT_BNE = 26, ONEHOT_SLTI = 27,
                  ONEHOT_SLTIU = 28, ONEHOT_J = 29, ONEHOT_JAL = 30, ONEHOT_RSVD = 31;
   // body keeps instr[25:0]; every extracted field lives inside it
   typedef struct packed {
      logic [25:0]      body;
      logic [DEC_W-1:0] onehot;
      logic             illegal;
   } entry_t;
endpackage

// File: rtl/instr_onehot_decode.sv
// instr_onehot_decode: combinational opcode/funct -> one-hot instruction vector
// Ports: op (instr[31:26]), funct (instr[5:0]) in; onehot (32-bit), illegal (no bit set) out
module instr_onehot_decode
   import mips_isa_pkg::*;
(
   input  logic [5:0]       op,
   input  logic [5:0]       funct,
   output logic [DEC_W-1:0] onehot,
   output logic             illegal
);
   logic r;
   assign r = op == OP_RTYPE;
   assign onehot[ONEHOT_ADD]   = r && funct == FN_ADD;
   assign onehot[ONEHOT_ADDU]  = r && funct == FN_ADDU;
   assign onehot[ONEHOT_SUB]   = r && funct == FN_SUB;
   assign onehot[ONEHOT_SUBU]  = r && funct == FN_SUBU;
   assign onehot[ONEHOT_AND]   = r && funct == FN_AND;
   assign onehot[ONEHOT_OR]    = r && funct == FN_OR;
   assign onehot[ONEHOT_XOR]   = r && funct == FN_XOR;
   assign onehot[ONEHOT_NOR]   = r && funct == FN_NOR;
   assign onehot[ONEHOT_SLT]   = r && funct == FN_SLT;
   assign onehot[ONEHOT_SLTU]  = r && funct == FN_SLTU;
   assign onehot[ONEHOT_SLL]   = r && funct == FN_SLL;
   assign onehot[ONEHOT_SRL]   = r && funct == FN_SRL;
   assign onehot[ONEHOT_SRA]   = r && funct == FN_SRA;
   assign onehot[ONEHOT_SLLV]  = r && funct == FN_SLLV;
   assign onehot[ONEHOT_SRLV]  = r && funct == FN_SRLV;
   assign onehot[ONEHOT_SRAV]  = r && funct == FN_SRAV;
   assign onehot[ONEHOT_JR]    = r && funct == FN_JR;
   assign onehot[ONEHOT_ADDI]  = op == OP_ADDI;
   assign onehot[ONEHOT_ADDIU] = op == OP_ADDIU;
   assign onehot[ONEHOT_ANDI]  = op == OP_ANDI;
   assign onehot[ONEHOT_ORI]   = op == OP_ORI;
   assign onehot[ONEHOT_XORI]  = op == OP_XORI;
   assign onehot[ONEHOT_LUI]   = op == OP_LUI;
   assign onehot[ONEHOT_LW]    = op == OP_LW;
   assign onehot[ONEHOT_SW]    = op == OP_SW;
   assign onehot[ONEHOT_BEQ]   = op == OP_BEQ;
   assign onehot[ONEHOT_BNE]   = op == OP_BNE;
   assign onehot[ONEHOT_SLTI]  = op == OP_SLTI;
   assign onehot[ONEHOT_SLTIU] = op == OP_SLTIU;
   assign onehot[ONEHOT_J]     = op == OP_J;
   assign onehot[ONEHOT_JAL]   = op == OP_JAL;
   assign onehot[ONEHOT_RSVD]  = 1'b0;
   assign illegal = ~|onehot;
endmodule

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: registered MIPS decode stage with 2-entry skid buffer, flush and illegal counter
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_instr/in_pc fetch side; flush;
//        out_valid/out_ready, out_decoded, out_rs/rt/rd/shamt/imm16/index26, out_pc, out_illegal;
//        illegal_count (saturating)
module instr_decode_stage
   import mips_isa_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int PC_W  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [PC_W-1:0]  in_pc,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_decoded,
   output logic [4:0]       out_rs,
   output logic [4:0]       out_rt,
   output logic [4:0]       out_rd,
   output logic [4:0]       out_shamt,
   output logic [15:0]      out_imm16,
   output logic [25:0]      out_index26,
   output logic [PC_W-1:0]  out_pc,
   output logic             out_illegal,
   output logic [CNT_W-1:0] illegal_count
);
   entry_t           in_entry, out_q, skid_q;
   logic [PC_W-1:0]  out_pc_q, skid_pc;
   logic             out_v, skid_v, accept, load_out, ill;
   logic [DEC_W-1:0] dec;
   logic [CNT_W-1:0] cnt;
   instr_onehot_decode u_dec (.op(in_instr[31:26]), .funct(in_instr[5:0]), .onehot(dec), .illegal(ill));
   assign in_entry = '{body: in_instr[25:0], onehot: dec, illegal: ill};
   assign accept   = in_valid && in_ready && !flush;
   // output register can take a new entry this cycle (empty or being drained)
   assign load_out = !out_v || out_ready;
   always_ff @(posedge clk) begin
      if (rst) begin
         out_v    <= 1'b0;
         skid_v   <= 1'b0;
         out_q    <= '0;
         out_pc_q <= '0;
         skid_q   <= '0;
         skid_pc  <= '0;
         cnt      <= '0;
      end else if (flush) begin
         out_v  <= 1'b0;
         skid_v <= 1'b0;
      end else begin
         // skid full implies in_ready low, so accept and skid refill never coincide
         if (load_out && skid_v) begin
            out_q    <= skid_q;
            out_pc_q <= skid_pc;
            skid_v   <= 1'b0;
         end else if (load_out) begin
            out_v <= accept;
            if (accept) begin
               out_q    <= in_entry;
               out_pc_q <= in_pc;
            end
         end else if (accept) begin
            skid_q  <= in_entry;
            skid_pc <= in_pc;
            skid_v  <= 1'b1;
         end
         if (accept && in_entry.illegal && cnt != '1) cnt <= cnt + 1'b1;
      end
   end
   assign in_ready      = !skid_v;
   assign out_valid     = out_v;
   assign out_decoded   = out_q.onehot;
   assign out_illegal   = out_q.illegal;
   assign out_rs        = out_q.body[25:21];
   assign out_rt        = out_q.body[20:16];
   assign out_rd        = out_q.body[15:11];
   assign out_shamt     = out_q.body[10:6];
   assign out_imm16     = out_q.body[15:0];
   assign out_index26   = out_q.body;
   assign out_pc        = out_pc_q;
   assign illegal_count = cnt;
endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: directed table, corner sequences and random traffic against a FIFO model
module tb_instr_decode_stage;
   logic clk = 1'b0, rst, in_valid, flush, out_ready;
   logic [31:0] in_instr, in_pc;
   logic in_ready, out_valid, out_illegal;
   logic [31:0] out_decoded, out_pc;
   logic [4:0] out_rs, out_rt, out_rd, out_shamt;
   logic [15:0] out_imm16;
   logic [25:0] out_index26;
   logic [15:0] illegal_count;
   logic in_ready2, out_valid2, out_illegal2;
   logic [31:0] out_decoded2, out_pc2;
   logic [4:0] out_rs2, out_rt2, out_rd2, out_shamt2;
   logic [15:0] out_imm162;
   logic [25:0] out_index262;
   logic [1:0] illegal_count2;
   int n_tests = 0, n_fail = 0;
   always #5 clk = ~clk;
   instr_decode_stage #(.CNT_W(16), .PC_W(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_decoded(out_decoded), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
      .out_shamt(out_shamt), .out_imm16(out_imm16), .out_index26(out_index26), .out_pc(out_pc),
      .out_illegal(out_illegal), .illegal_count(illegal_count));
   instr_decode_stage #(.CNT_W(2), .PC_W(32)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_instr(in_instr),
      .in_pc(in_pc), .flush(flush), .out_valid(out_valid2), .out_ready(out_ready),
      .out_decoded(out_decoded2), .out_rs(out_rs2), .out_rt(out_rt2), .out_rd(out_rd2),
      .out_shamt(out_shamt2), .out_imm16(out_imm162), .out_index26(out_index262), .out_pc(out_pc2),
      .out_illegal(out_illegal2), .illegal_count(illegal_count2));
   // bit i of the one-hot vector: bit6 set = R-type funct code, else primary opcode
   localparam logic [6:0] CODE [0:30] = '{
      7'h60, 7'h61, 7'h62, 7'h63, 7'h64, 7'h65, 7'h66, 7'h67, 7'h6A, 7'h6B,
      7'h40, 7'h42, 7'h43, 7'h44, 7'h46, 7'h47, 7'h48,
      7'h08, 7'h09, 7'h0C, 7'h0D, 7'h0E, 7'h0F, 7'h23, 7'h2B, 7'h04, 7'h05, 7'h0A, 7'h0B, 7'h02, 7'h03};
   typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
   typedef struct { logic [31:0] instr; logic [31:0] dec; } vec_t;
   ent_t q[$];
   int cnt = 0, cnt2 = 0;
   function automatic logic [31:0] ref_dec(input logic [31:0] w);
      logic [6:0] c;
      for (int i = 0; i < 31; i++) begin
         c = CODE[i];
         if (c[6] ? (w[31:26] == 6'h00 && w[5:0] == c[5:0]) : (w[31:26] == c[5:0])) return 32'h1 << i;
      end
      return 32'h0;
   endfunction
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic check_all();
      ent_t e;
      chk("in_ready", in_ready, q.size() < 2);
      chk("out_valid", out_valid, q.size() > 0);
      chk("illegal_count", illegal_count, cnt);
      chk("illegal_count_w2", illegal_count2, cnt2);
      if (q.size() > 0) begin
         e = q[0];
         chk("decoded", out_decoded, ref_dec(e.instr));
         chk("illegal", out_illegal, ref_dec(e.instr) == 0);
         chk("rs", out_rs, e.instr[25:21]);
         chk("rt", out_rt, e.instr[20:16]);
         chk("rd", out_rd, e.instr[15:11]);
         chk("shamt", out_shamt, e.instr[10:6]);
         chk("imm16", out_imm16, e.instr[15:0]);
         chk("index26", out_index26, e.instr[25:0]);
         chk("pc", out_pc, e.pc);
      end
   endtask
   task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl, input logic r);
      bit acc, drn;
      in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl; rst = r;
      acc = iv && q.size() < 2 && !fl;
      drn = q.size() > 0 && ordy;
      @(posedge clk); #1;
      if (r) begin
         q.delete(); cnt = 0; cnt2 = 0;
      end else if (fl) q.delete();
      else begin
         if (drn) void'(q.pop_front());
         if (acc) begin
            q.push_back('{ins, pc});
            if (ref_dec(ins) == 0) begin
               if (cnt < 65535) cnt++;
               if (cnt2 < 3) cnt2++;
            end
         end
      end
      check_all();
   endtask
   function automatic logic [31:0] gen();
      logic [31:0] rnd;
      logic [6:0] c;
      rnd = $urandom;
      if ($urandom_range(0, 3) == 0) return rnd;
      c = CODE[$urandom_range(0, 30)];
      return c[6] ? {6'h00, rnd[25:6], c[5:0]} : {c[5:0], rnd[25:0]};
   endfunction
   initial begin
      vec_t tbl[10];
      int saved;
      tbl = '{'{32'h00000022, 32'h00000004}, '{32'h00000008, 32'h00010000},
              '{32'h20000000, 32'h00020000}, '{32'h08000000, 32'h20000000},
              '{32'h00000000, 32'h00000400}, '{32'h00000001, 32'h00000000},
              '{32'h10000000, 32'h02000000}, '{32'hAC000000, 32'h01000000},
              '{32'h3C000000, 32'h00400000}, '{32'h0000002B, 32'h00000200}};
      step(0, 0, 0, 1, 0, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_count", illegal_count, 0);
      chk("rst_decoded", out_decoded, 0);
      chk("rst_pc", out_pc, 0);
      step(1, 32'h012A4020, 32'h100, 1, 0, 0);
      chk("add_dec", out_decoded, 32'h1);
      chk("add_rs", out_rs, 9);
      chk("add_rt", out_rt, 10);
      chk("add_rd", out_rd, 8);
      step(1, 32'h8D090004, 32'h104, 1, 0, 0);
      chk("lw_dec", out_decoded, 32'h00800000);
      chk("lw_imm", out_imm16, 4);
      step(1, 32'h0C000010, 32'h108, 1, 0, 0);
      chk("jal_dec", out_decoded, 32'h40000000);
      chk("jal_idx", out_index26, 26'h10);
      for (int i = 0; i < 10; i++) begin
         step(1, tbl[i].instr, 32'h200 + 4 * i, 1, 0, 0);
         chk("tbl_dec", out_decoded, tbl[i].dec);
         chk("tbl_ill", out_illegal, tbl[i].dec == 0);
      end
      step(0, 0, 0, 1, 0, 1);
      step(1, 32'hFC000000, 32'h300, 1, 0, 0);
      chk("ill_dec", out_decoded, 0);
      chk("ill_flag", out_illegal, 1);
      chk("ill_count1", illegal_count, 1);
      for (int i = 0; i < 4; i++) step(1, 32'hFC000000, 32'h304 + 4 * i, 1, 0, 0);
      chk("ill_count5", illegal_count, 5);
      chk("ill_sat_w2", illegal_count2, 3);
      step(0, 0, 0, 1, 0, 0);
      step(1, 32'h012A4020, 32'h400, 0, 0, 0);
      step(1, 32'h8D090004, 32'h404, 0, 0, 0);
      chk("stall_in_ready_low", in_ready, 0);
      step(1, 32'h0C000010, 32'h408, 0, 0, 0);
      step(1, 32'h0C000010, 32'h408, 0, 0, 0);
      chk("stall_hold_pc", out_pc, 32'h400);
      step(1, 32'h0C000010, 32'h408, 1, 0, 0);
      chk("drain_pc2", out_pc, 32'h404);
      chk("drain_in_ready", in_ready, 1);
      step(1, 32'h0C000010, 32'h408, 1, 0, 0);
      chk("drain_pc3", out_pc, 32'h408);
      step(0, 0, 0, 1, 0, 0);
      chk("drain_empty", out_valid, 0);
      step(1, 32'h00000022, 32'h500, 0, 0, 0);
      step(1, 32'hFC000000, 32'h504, 0, 0, 0);
      saved = illegal_count;
      step(1, 32'hFC000000, 32'h508, 0, 1, 0);
      chk("flush_full_valid", out_valid, 0);
      chk("flush_full_ready", in_ready, 1);
      chk("flush_full_count", illegal_count, saved);
      step(1, 32'hFC000000, 32'h50C, 1, 1, 0);
      chk("flush_drop_valid", out_valid, 0);
      chk("flush_drop_count", illegal_count, saved);
      step(1, 32'hFC000000, 32'h600, 0, 0, 0);
      step(1, 32'h00000022, 32'h604, 0, 0, 0);
      step(0, 0, 0, 0, 1, 1);
      chk("rst_full_valid", out_valid, 0);
      chk("rst_full_ready", in_ready, 1);
      chk("rst_full_count", illegal_count, 0);
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 3) != 0, gen(), $urandom, $urandom_range(0, 2) != 0,
              $urandom_range(0, 40) == 0, $urandom_range(0, 150) == 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
